// File: rtl/periph_bus_bridge.sv
// periph_bus_bridge: decodes core data accesses into RAM, IO register bank and external cmd/rsp channel
module periph_bus_bridge #(
  parameter int DATA_W  = 32,
  parameter int NUM_IO  = 4,
  parameter int IO_W    = 16,
  parameter int EXT_AW  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   core_sel,
  input  logic [31:0]            core_addr,
  input  logic                   core_we,
  input  logic [DATA_W/8-1:0]    core_wmask,
  input  logic [DATA_W-1:0]      core_wdata,
  output logic [DATA_W-1:0]      core_rdata,
  output logic                   core_valid,
  input  logic [DATA_W-1:0]      ram_rdata,
  output logic                   ext_cmd_valid,
  output logic                   ext_cmd_write,
  output logic [EXT_AW-1:0]      ext_cmd_addr,
  output logic [DATA_W-1:0]      ext_cmd_data,
  output logic [DATA_W/8-1:0]    ext_cmd_strb,
  input  logic                   ext_cmd_busy,
  input  logic                   ext_rsp_stb,
  input  logic [DATA_W-1:0]      ext_rsp_word,
  output logic [NUM_IO*IO_W-1:0] io_out,
  output logic                   err_timeout
);
  localparam int SW    = DATA_W / 8;
  localparam int IDX_W = $clog2(NUM_IO + 1);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   cmd_write_q, cmd_write_d;
  logic [EXT_AW-1:0]      cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]      cmd_data_q, cmd_data_d;
  logic [SW-1:0]          cmd_strb_q, cmd_strb_d;
  logic [NUM_IO*IO_W-1:0] io_q, io_d;
  logic                   err_q, err_d;
  logic                   is_io, is_ext, io_wr, to_set, st_clr;
  logic [IDX_W-1:0]       idx;
  logic [DATA_W-1:0]      io_rd, bit_en;
  logic                   unused_addr;
  assign is_io       = core_sel && core_addr[31:30] == 2'b10;
  assign is_ext      = core_sel && core_addr[31:30] == 2'b11;
  assign idx         = core_addr[2 +: IDX_W];
  assign io_wr       = is_io && core_we;
  assign st_clr      = io_wr && idx == IDX_W'(NUM_IO) && core_wdata[0] && core_wmask[0];
  assign unused_addr = ^core_addr;
  for (genvar g = 0; g < SW; g++) begin : g_lane
    assign bit_en[g*8 +: 8] = {8{core_wmask[g]}};
  end
  // IO bank: byte-masked register writes and zero-extended readback, status word above the bank
  always_comb begin
    io_d  = io_q;
    io_rd = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      if (idx == IDX_W'(i)) begin
        io_rd = DATA_W'(io_q[i*IO_W +: IO_W]);
        if (io_wr) io_d[i*IO_W +: IO_W] = (io_q[i*IO_W +: IO_W] & ~bit_en[IO_W-1:0]) | (core_wdata[IO_W-1:0] & bit_en[IO_W-1:0]);
      end
    end
    if (idx == IDX_W'(NUM_IO)) io_rd = DATA_W'(err_q);
  end
  // External channel FSM: capture, issue under back-pressure, wait for response or timeout, one-cycle done
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    cmd_strb_d  = cmd_strb_q;
    to_set      = 1'b0;
    case (state_q)
      S_IDLE: if (is_ext) begin
        state_d     = S_ISSUE;
        cmd_write_d = core_we;
        cmd_addr_d  = core_addr[EXT_AW-1:0];
        cmd_data_d  = core_wdata;
        cmd_strb_d  = core_wmask;
      end
      S_ISSUE: if (!ext_cmd_busy) begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: if (ext_rsp_stb) begin
        rdata_d = ext_rsp_word;
        state_d = S_DONE;
      end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        rdata_d = '1;
        to_set  = 1'b1;
        state_d = S_DONE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // Sticky timeout flag: a new timeout overrides a simultaneous software clear
  always_comb err_d = to_set ? 1'b1 : st_clr ? 1'b0 : err_q;
  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rdata_q     <= '0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      cmd_strb_q  <= '0;
      io_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      cmd_strb_q  <= cmd_strb_d;
      io_q        <= io_d;
      err_q       <= err_d;
    end
  end
  assign core_valid    = is_ext ? state_q == S_DONE : 1'b1;
  assign core_rdata    = is_ext ? rdata_q : is_io ? io_rd : ram_rdata;
  assign ext_cmd_valid = state_q == S_ISSUE;
  assign ext_cmd_write = cmd_write_q;
  assign ext_cmd_addr  = cmd_addr_q;
  assign ext_cmd_data  = cmd_data_q;
  assign ext_cmd_strb  = cmd_strb_q;
  assign io_out        = io_q;
  assign err_timeout   = err_q;
endmodule

// File: tb/tb_periph_bus_bridge.sv
// tb_periph_bus_bridge: directed self-checking bench for periph_bus_bridge (TIMEOUT=8)
module tb_periph_bus_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        core_sel, core_we, core_valid;
  logic [31:0] core_addr, core_wdata, core_rdata, ram_rdata;
  logic [3:0]  core_wmask;
  logic        ext_cmd_valid, ext_cmd_write, ext_cmd_busy, ext_rsp_stb;
  logic [3:0]  ext_cmd_addr, ext_cmd_strb;
  logic [31:0] ext_cmd_data, ext_rsp_word;
  logic [63:0] io_out;
  logic        err_timeout;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cmd_cnt = 0;
  int          c0, lat, nis;
  logic [31:0] rd, cd;
  logic [3:0]  ca, cs;
  logic        cw;
  always #5 clk = ~clk;
  // Counts cycles with a command on the external channel
  always @(posedge clk) if (ext_cmd_valid) cmd_cnt++;
  periph_bus_bridge #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .core_sel(core_sel), .core_addr(core_addr), .core_we(core_we),
    .core_wmask(core_wmask), .core_wdata(core_wdata), .core_rdata(core_rdata), .core_valid(core_valid),
    .ram_rdata(ram_rdata), .ext_cmd_valid(ext_cmd_valid), .ext_cmd_write(ext_cmd_write),
    .ext_cmd_addr(ext_cmd_addr), .ext_cmd_data(ext_cmd_data), .ext_cmd_strb(ext_cmd_strb),
    .ext_cmd_busy(ext_cmd_busy), .ext_rsp_stb(ext_rsp_stb), .ext_rsp_word(ext_rsp_word),
    .io_out(io_out), .err_timeout(err_timeout)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic io_acc(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] wm);
    core_sel = 1'b1; core_addr = a; core_we = we; core_wdata = wd; core_wmask = wm;
    #1;
  endtask
  // Runs one external access; busy is held for busy_n ISSUE cycles, rsp_stb on WAIT cycle rsp_at (0 = never)
  task automatic ext_run(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] wm,
                         input int busy_n, input int rsp_at, input logic [31:0] rw,
                         output int lt, output logic [31:0] r, output int ni,
                         output logic [3:0] xa, output logic xw, output logic [31:0] xd, output logic [3:0] xs);
    int  w;
    bit  acc, done;
    core_sel = 1'b1; core_addr = a; core_we = we; core_wdata = wd; core_wmask = wm;
    ext_cmd_busy = 1'b0; ext_rsp_stb = 1'b0; ext_rsp_word = rw;
    lt = 0; ni = 0; w = 0; acc = 0; done = 0; r = '0; xa = '0; xw = 1'b0; xd = '0; xs = '0;
    for (int c = 1; c <= 40 && !done; c++) begin
      step;
      lt = c;
      ext_rsp_stb = 1'b0;
      if (core_valid) begin
        r = core_rdata;
        done = 1;
      end else if (ext_cmd_valid) begin
        if (ni == 0) begin
          xa = ext_cmd_addr; xw = ext_cmd_write; xd = ext_cmd_data; xs = ext_cmd_strb;
        end
        ext_cmd_busy = ni < busy_n;
        ni++;
        if (!ext_cmd_busy) acc = 1;
      end else if (acc) begin
        w++;
        ext_rsp_stb = w == rsp_at;
      end
    end
    chk("ext_completes", done, 1'b1);
    ext_cmd_busy = 1'b0;
    step;
    chk("valid_one_cycle", core_valid, 1'b0);
    core_sel = 1'b0;
    #1;
  endtask
  initial begin
    core_sel = 0; core_addr = 0; core_we = 0; core_wmask = 0; core_wdata = 0;
    ram_rdata = 32'h1111_2222; ext_cmd_busy = 0; ext_rsp_stb = 0; ext_rsp_word = 0;
    @(negedge clk);
    chk("rst_io_out", io_out, 64'h0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_cmd_valid", ext_cmd_valid, 1'b0);
    chk("rst_cmd_addr", ext_cmd_addr, 4'h0);
    chk("idle_valid", core_valid, 1'b1);
    chk("idle_rdata", core_rdata, 32'h1111_2222);
    rst = 1'b1;
    step;
    c0 = cmd_cnt;
    ram_rdata = 32'hA5A5_0001;
    io_acc(32'h0000_1000, 1'b0, 32'h0, 4'h0);
    chk("ram_valid", core_valid, 1'b1);
    chk("ram_rdata", core_rdata, 32'hA5A5_0001);
    io_acc(32'h0000_1000, 1'b1, 32'hFFFF_FFFF, 4'hF);
    step;
    chk("ram_wr_valid", core_valid, 1'b1);
    chk("ram_no_cmd", cmd_cnt - c0, 0);
    chk("ram_no_io", io_out, 64'h0);
    io_acc(32'h8000_0004, 1'b1, 32'h0000_ABCD, 4'b0001);
    chk("io_wr_valid", core_valid, 1'b1);
    step;
    io_acc(32'h8000_0004, 1'b0, 32'h0, 4'h0);
    chk("io1_lane0", io_out, 64'h0000_0000_00CD_0000);
    chk("io1_read", core_rdata, 32'h0000_00CD);
    chk("io1_rd_valid", core_valid, 1'b1);
    io_acc(32'h8000_0000, 1'b1, 32'h1234_5678, 4'hF);
    step;
    io_acc(32'h8000_0000, 1'b0, 32'h0, 4'h0);
    chk("io0_full", core_rdata, 32'h0000_5678);
    io_acc(32'h8000_000C, 1'b1, 32'hFFFF_BEEF, 4'b0010);
    step;
    io_acc(32'h8000_000C, 1'b0, 32'h0, 4'h0);
    chk("io3_lane1", core_rdata, 32'h0000_BE00);
    chk("io_bank", io_out, 64'hBE00_0000_00CD_5678);
    io_acc(32'h8000_0014, 1'b1, 32'hFFFF_FFFF, 4'hF);
    step;
    io_acc(32'h8000_0014, 1'b0, 32'h0, 4'h0);
    chk("io5_read_zero", core_rdata, 32'h0);
    chk("io5_wr_ignored", io_out, 64'hBE00_0000_00CD_5678);
    io_acc(32'h8000_0010, 1'b0, 32'h0, 4'h0);
    chk("status_clear", core_rdata, 32'h0);
    io_acc(32'hC000_0008, 1'b0, 32'h0, 4'h0);
    chk("ext_stall", core_valid, 1'b0);
    step;
    chk("issue_cmd_valid", ext_cmd_valid, 1'b1);
    step;
    repeat (5) step;
    chk("wait_cmd_low", ext_cmd_valid, 1'b0);
    chk("wait_stall", core_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk("arst_cmd_valid", ext_cmd_valid, 1'b0);
    chk("arst_io_out", io_out, 64'h0);
    chk("arst_cmd_addr", ext_cmd_addr, 4'h0);
    core_sel = 1'b0;
    step;
    rst = 1'b1;
    ext_run(32'hC000_0008, 1'b0, 32'h0, 4'h0, 0, 1, 32'hCAFE_F00D, lat, rd, nis, ca, cw, cd, cs);
    chk("min_latency", lat, 3);
    chk("post_rst_rdata", rd, 32'hCAFE_F00D);
    chk("post_rst_addr", ca, 4'h8);
    ext_run(32'hC000_0004, 1'b0, 32'h0, 4'h0, 3, 2, 32'h1234_5678, lat, rd, nis, ca, cw, cd, cs);
    chk("busy_latency", lat, 7);
    chk("busy_issue_cycles", nis, 4);
    chk("busy_cmd_addr", ca, 4'h4);
    chk("busy_cmd_write", cw, 1'b0);
    chk("busy_rdata", rd, 32'h1234_5678);
    chk("busy_no_err", err_timeout, 1'b0);
    ext_run(32'hC000_000C, 1'b1, 32'hDEAD_BEEF, 4'b0011, 1, 3, 32'h0, lat, rd, nis, ca, cw, cd, cs);
    chk("wr_latency", lat, 6);
    chk("wr_cmd_addr", ca, 4'hC);
    chk("wr_cmd_write", cw, 1'b1);
    chk("wr_cmd_data", cd, 32'hDEAD_BEEF);
    chk("wr_cmd_strb", cs, 4'b0011);
    ext_run(32'hC000_0000, 1'b0, 32'h0, 4'h0, 0, 0, 32'h0, lat, rd, nis, ca, cw, cd, cs);
    chk("to_latency", lat, 10);
    chk("to_rdata", rd, 32'hFFFF_FFFF);
    chk("to_err_set", err_timeout, 1'b1);
    io_acc(32'h8000_0010, 1'b0, 32'h0, 4'h0);
    chk("status_read_set", core_rdata, 32'h1);
    io_acc(32'h8000_0010, 1'b1, 32'h1, 4'h0);
    step;
    chk("status_nomask_keep", err_timeout, 1'b1);
    io_acc(32'h8000_0010, 1'b1, 32'h0, 4'h1);
    step;
    chk("status_zero_keep", err_timeout, 1'b1);
    io_acc(32'h8000_0010, 1'b1, 32'h1, 4'h1);
    step;
    io_acc(32'h8000_0010, 1'b0, 32'h0, 4'h0);
    chk("status_cleared", err_timeout, 1'b0);
    chk("status_read_clr", core_rdata, 32'h0);
    core_sel = 1'b0;
    ext_run(32'hC000_0004, 1'b0, 32'h0, 4'h0, 0, 8, 32'h55AA_55AA, lat, rd, nis, ca, cw, cd, cs);
    chk("edge_latency", lat, 10);
    chk("edge_rdata", rd, 32'h55AA_55AA);
    chk("edge_no_err", err_timeout, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
